// File: rtl/fetch_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_arbiter_pkg
// Description : Shared types for the instruction-fetch channel arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_arbiter_pkg;

    localparam int c_addr_width  = 16;
    localparam int c_instr_width = 32;

    typedef logic [c_addr_width-1:0]  instruction_memory_address_t;
    typedef logic [c_instr_width-1:0] instruction_t;
    typedef instruction_memory_address_t addr_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        RELAY     = 2'd2,
        RELEASE   = 2'd3
    } fetch_channel_state_t;

    // Explicit wrap so non-power-of-two consumer counts stay in range.
    function automatic int rr_advance(input int last, input int n);
        return (last >= n - 1) ? 0 : last + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : fetch_rr_picker
// Description : First set request at or after rr_ptr, scanning modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;

    always_comb begin
        winner     = '0;
        found      = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand     = (int'(rr_ptr) + k) % NUM_REQ;
            w_cand_idx = IDX_W'(w_cand);
            if (!found && req[w_cand_idx]) begin
                found  = 1'b1;
                winner = w_cand_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_arbiter
// Description : Round-robin sharing of instruction-memory read channels among
//               per-warp fetchers; one outstanding read per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_arbiter
    import fetch_arbiter_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  addr_t                    consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output instruction_t             consumer_read_data    [NUM_CONSUMERS],
    output logic [NUM_CHANNELS-1:0]  mem_read_valid,
    output addr_t                    mem_read_address      [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
    input  instruction_t             mem_read_data         [NUM_CHANNELS]
);

    localparam int c_idx_w = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    fetch_channel_state_t r_state      [NUM_CHANNELS];
    fetch_channel_state_t w_state_next [NUM_CHANNELS];
    logic [c_idx_w-1:0]   r_owner      [NUM_CHANNELS];
    addr_t                r_addr       [NUM_CHANNELS];
    instruction_t         r_cons_data  [NUM_CONSUMERS];
    logic [c_idx_w-1:0]   r_rr_ptr;

    logic [NUM_CONSUMERS-1:0] w_owned;
    logic [NUM_CONSUMERS-1:0] w_eligible;
    logic [NUM_CHANNELS-1:0]  w_grant;
    logic [c_idx_w-1:0]       w_grant_idx [NUM_CHANNELS];
    logic [c_idx_w-1:0]       w_last_idx;
    logic [c_idx_w-1:0]       w_rr_next;

    // A consumer held by any non-idle channel (including RELEASE) is not re-eligible.
    always_comb begin
        w_owned = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (r_state[c] != IDLE) begin
                w_owned[r_owner[c]] = 1'b1;
            end
        end
        w_eligible = consumer_read_valid & ~w_owned;
    end

    // Each channel's picker sees the requests left over by lower-indexed grants.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [NUM_CONSUMERS-1:0] w_req;
        logic [NUM_CONSUMERS-1:0] w_req_next;
        logic [c_idx_w-1:0]       w_pick;
        logic                     w_found;

        if (c == 0) begin : g_first
            assign w_req = w_eligible;
        end else begin : g_chain
            assign w_req = g_ch[c-1].w_req_next;
        end

        fetch_rr_picker #(
            .NUM_REQ (NUM_CONSUMERS),
            .IDX_W   (c_idx_w)
        ) u_picker (
            .req    (w_req),
            .rr_ptr (r_rr_ptr),
            .winner (w_pick),
            .found  (w_found)
        );

        assign w_grant[c]     = w_found && (r_state[c] == IDLE);
        assign w_grant_idx[c] = w_pick;
        assign w_req_next     = w_grant[c] ? (w_req & ~(NUM_CONSUMERS'(1) << w_pick)) : w_req;
    end

    // Highest granting channel holds the last winner in scan order.
    always_comb begin
        w_last_idx = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_grant[c]) begin
                w_last_idx = w_grant_idx[c];
            end
        end
        w_rr_next = c_idx_w'(rr_advance(int'(w_last_idx), NUM_CONSUMERS));
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_state_next[c] = r_state[c];
            case (r_state[c])
                IDLE:      if (w_grant[c]) w_state_next[c] = READ_WAIT;
                READ_WAIT: if (mem_read_ready[c]) w_state_next[c] = RELAY;
                RELAY:     w_state_next[c] = RELEASE;
                RELEASE:   if (!consumer_read_valid[r_owner[c]]) w_state_next[c] = IDLE;
                default:   w_state_next[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_state[c] <= IDLE;
                r_owner[c] <= '0;
                r_addr[c]  <= '0;
            end
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                r_cons_data[i] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_state[c] <= w_state_next[c];
                if (w_grant[c]) begin
                    r_owner[c] <= w_grant_idx[c];
                    r_addr[c]  <= consumer_read_address[w_grant_idx[c]];
                end
                if ((r_state[c] == READ_WAIT) && mem_read_ready[c]) begin
                    r_cons_data[r_owner[c]] <= mem_read_data[c];
                end
            end
            if (|w_grant) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    always_comb begin
        mem_read_valid      = '0;
        consumer_read_ready = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            mem_read_valid[c]   = (r_state[c] == READ_WAIT);
            mem_read_address[c] = (r_state[c] == READ_WAIT) ? r_addr[c] : '0;
            if (r_state[c] == RELAY) begin
                consumer_read_ready[r_owner[c]] = 1'b1;
            end
        end
    end

    // Per-consumer data registers keep their last relayed value.
    assign consumer_read_data = r_cons_data;

endmodule
`default_nettype wire
